// File: rtl/shift_arb.sv
// -----------------------------------------------------------------------------
// shift_arb
//
// Two requesters share one barrel shifter. Requester 0 is the datapath and
// requester 1 is the microprogram sequencer. Each cycle at most one of them is
// granted. The granted operation is shifted and its result is registered into
// a single-entry output slot.
//
// The slot can be drained and refilled in the same cycle, so the block can
// accept one operation per cycle while the consumer keeps out_ready high.
//
// Optional feature macro:
//   SHIFT_ARB_RR_EN  defined   -> round-robin arbitration on simultaneous
//                                 requests (a one-bit pointer picks the winner)
//                    undefined -> fixed priority, requester 0 always wins
//
// Parameters:
//   WIDTH  operand / result width in bits
//   SHW    shift-amount width (log2 WIDTH)
//
// Ports:
//   clk                      rising-edge clock
//   reset_n                  asynchronous, active-low reset
//   req0_valid / req1_valid  requester presents an operation
//   req0_a / req1_a          operand
//   req0_shamt / req1_shamt  shift amount
//   req0_sh / req1_sh        shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR
//   req0_ready / req1_ready  operation accepted this cycle (combinational)
//   out_valid                result slot holds an unconsumed result
//   out_data                 shifted result
//   out_id                   index of the requester that issued the result
//   out_ready                consumer takes the result this cycle
// -----------------------------------------------------------------------------
module shift_arb #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [SHW-1:0]   req0_shamt,
    input  logic [1:0]       req0_sh,
    output logic             req0_ready,

    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [SHW-1:0]   req1_shamt,
    input  logic [1:0]       req1_sh,
    output logic             req1_ready,

    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id,
    input  logic             out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_id_q, out_id_d;

`ifdef SHIFT_ARB_RR_EN
    logic             rr_ptr_q, rr_ptr_d;
`endif

    logic             slot_free;
    logic             grant0, grant1, grant_any;

    logic [WIDTH-1:0] sel_a;
    logic [SHW-1:0]   sel_shamt;
    logic [1:0]       sel_sh;
    logic [SHW:0]     ror_left;
    logic [WIDTH-1:0] shift_result;

    // Arbitration. The slot is free when empty or when the held result is
    // drained this cycle. Grants are gated by reset_n so nothing is accepted
    // while reset is held low, even though the state register already reads
    // EMPTY at that point.
    always_comb begin
        slot_free = (state_q == EMPTY) || out_ready;
        grant0    = 1'b0;
        grant1    = 1'b0;
        if (slot_free && reset_n) begin
`ifdef SHIFT_ARB_RR_EN
            if (req0_valid && req1_valid) begin
                grant0 = ~rr_ptr_q;
                grant1 = rr_ptr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
`else
            grant0 = req0_valid;
            grant1 = req1_valid && !req0_valid;
`endif
        end
        grant_any = grant0 || grant1;
    end

    // Operand mux and barrel shifter. The rotate is built from two
    // logical shifts. With a shift amount of 0 the left part shifts by
    // WIDTH and contributes nothing, so the operand passes through unchanged.
    always_comb begin
        sel_a     = grant1 ? req1_a     : req0_a;
        sel_shamt = grant1 ? req1_shamt : req0_shamt;
        sel_sh    = grant1 ? req1_sh    : req0_sh;
        ror_left  = (SHW+1)'(WIDTH) - {1'b0, sel_shamt};

        shift_result = '0;
        case (sel_sh)
            2'b00:   shift_result = sel_a << sel_shamt;
            2'b01:   shift_result = sel_a >> sel_shamt;
            2'b10:   shift_result = $signed(sel_a) >>> sel_shamt;
            default: shift_result = (sel_a >> sel_shamt) | (sel_a << ror_left);
        endcase
    end

    // Next-state logic. A grant always fills the slot, which covers
    // same-cycle drain and refill. Without a grant, a drained slot empties
    // and an undrained slot keeps its contents.
    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_id_d   = out_id_q;
        if (grant_any) begin
            state_d    = FULL;
            out_data_d = shift_result;
            out_id_d   = grant1;
        end else if (out_ready) begin
            state_d    = EMPTY;
        end
    end

`ifdef SHIFT_ARB_RR_EN
    // After every grant the pointer moves to the requester that did not win.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = grant0;
        end
    end
`endif

    // State register. Reset clears the held result at once, with no clock
    // edge needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            out_data_q <= '0;
            out_id_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            out_id_q   <= out_id_d;
        end
    end

`ifdef SHIFT_ARB_RR_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Output logic.
    always_comb begin
        out_valid  = (state_q == FULL);
        out_data   = out_data_q;
        out_id     = out_id_q;
        req0_ready = grant0;
        req1_ready = grant1;
    end

endmodule

// File: tb/tb_shift_arb.sv
// -----------------------------------------------------------------------------
// tb_shift_arb
//
// Self-checking bench for shift_arb (WIDTH=32, SHW=5). A reference model
// tracks the result slot as a plain valid/data/id record. It computes shift
// results arithmetically (multiply, divide, bit-by-bit rotate). Every negedge
// it compares the DUT against the model and then advances the model by one
// cycle. Directed sequences add literal expectations on top of that.
// Build with +define+SHIFT_ARB_RR_EN to exercise the round-robin variant.
// -----------------------------------------------------------------------------
module tb_shift_arb;

    logic        clk;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req1_a;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [1:0]  req0_sh, req1_sh;
    logic        req0_ready, req1_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_id;
    logic        out_ready;

    int n_compared;
    int n_mismatched;

    shift_arb #(.WIDTH(32), .SHW(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req0_sh    (req0_sh),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .req1_sh    (req1_sh),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point. It counts every check and reports misses.
    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Shift rules written as arithmetic: LSL multiplies by 2^s, LSR
    // divides, ASR floors negative values through the complement, and ROR
    // picks each result bit from the operand at (i+s) mod 32.
    function automatic logic [31:0] refShift(input logic [31:0] a, input logic [4:0] s,
                                             input logic [1:0] t);
        logic [63:0] p;
        logic [31:0] r;
        p = 64'd1 << s;
        r = '0;
        case (t)
            2'b00: r = 32'({32'd0, a} * p);
            2'b01: r = 32'({32'd0, a} / p);
            2'b10: begin
                if (a[31]) r = ~(32'({32'd0, ~a} / p));
                else       r = 32'({32'd0, a} / p);
            end
            default: begin
                for (int i = 0; i < 32; i++) r[i] = a[(i + int'(s)) % 32];
            end
        endcase
        return r;
    endfunction

    // Model and per-cycle compare. Inputs change only just after a posedge,
    // so at the negedge they hold the values the next edge will use.
    initial begin : model_proc
        logic        m_valid;
        logic [31:0] m_data;
        logic        m_id;
        logic        m_ptr;
        logic        have_grant;
        logic        win;
        m_valid = 1'b0;
        m_data  = '0;
        m_id    = 1'b0;
        m_ptr   = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                compareVal("rst_out_valid",  32'(out_valid),  32'd0);
                compareVal("rst_out_data",   out_data,        32'd0);
                compareVal("rst_out_id",     32'(out_id),     32'd0);
                compareVal("rst_req0_ready", 32'(req0_ready), 32'd0);
                compareVal("rst_req1_ready", 32'(req1_ready), 32'd0);
                m_valid = 1'b0;
                m_data  = '0;
                m_id    = 1'b0;
                m_ptr   = 1'b0;
            end else begin
                compareVal("mdl_out_valid", 32'(out_valid), 32'(m_valid));
                if (m_valid) begin
                    compareVal("mdl_out_data", out_data,     m_data);
                    compareVal("mdl_out_id",   32'(out_id),  32'(m_id));
                end
                have_grant = (!m_valid || out_ready) && (req0_valid || req1_valid);
                if (req0_valid && req1_valid) begin
`ifdef SHIFT_ARB_RR_EN
                    win = m_ptr;
`else
                    win = 1'b0;
`endif
                end else begin
                    win = req1_valid;
                end
                compareVal("mdl_req0_ready", 32'(req0_ready), 32'(have_grant && !win));
                compareVal("mdl_req1_ready", 32'(req1_ready), 32'(have_grant && win));
                if (have_grant) begin
                    m_valid = 1'b1;
                    m_id    = win;
                    m_data  = win ? refShift(req1_a, req1_shamt, req1_sh)
                                  : refShift(req0_a, req0_shamt, req0_sh);
                    m_ptr   = !win;
                end else if (out_ready) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [4:0] s0,
                                 input logic [1:0] t0, input logic v1, input logic [31:0] a1,
                                 input logic [4:0] s1, input logic [1:0] t1, input logic ordy);
        req0_valid = v0;  req0_a = a0;  req0_shamt = s0;  req0_sh = t0;
        req1_valid = v1;  req1_a = a1;  req1_shamt = s1;  req1_sh = t1;
        out_ready  = ordy;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkReady(input string name, input logic e0, input logic e1);
        #1;
        compareVal({name, "_req0_ready"}, 32'(req0_ready), 32'(e0));
        compareVal({name, "_req1_ready"}, 32'(req1_ready), 32'(e1));
    endtask

    task automatic checkOutput(input string name, input logic ev, input logic [31:0] ed,
                               input logic eid);
        compareVal({name, "_valid"}, 32'(out_valid), 32'(ev));
        compareVal({name, "_data"},  out_data,       ed);
        compareVal({name, "_id"},    32'(out_id),    32'(eid));
    endtask

    function automatic logic [4:0] randShamt();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd31;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin : stim_proc
        logic exp_id;
        n_compared   = 0;
        n_mismatched = 0;
        reset_n = 1'b0;
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, '0, '0, 2'b00, 1'b0);

        // While reset is held, valid requests must not be accepted.
        repeat (2) tick();
        applyStimulus(1'b1, 32'd1, 5'd0, 2'b00, 1'b1, 32'd2, 5'd0, 2'b00, 1'b1);
        checkReady("in_reset", 1'b0, 1'b0);
        checkOutput("in_reset", 1'b0, 32'd0, 1'b0);
        reset_n = 1'b1;

        // Both requesters valid for four cycles with out_ready held high.
        for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_RR_EN
            exp_id = 1'(i % 2);
`else
            exp_id = 1'b0;
`endif
            applyStimulus(1'b1, 32'd1, 5'd0, 2'b00, 1'b1, 32'd2, 5'd0, 2'b00, 1'b1);
            checkReady("both", !exp_id, exp_id);
            tick();
            checkOutput("both", 1'b1, exp_id ? 32'd2 : 32'd1, exp_id);
        end

        // Requester 0 alone, LSL.
        applyStimulus(1'b1, 32'h0000_00F0, 5'd4, 2'b00, 1'b0, '0, '0, 2'b00, 1'b1);
        tick();
        checkOutput("lsl", 1'b1, 32'h0000_0F00, 1'b0);

        // Requester 1 alone: ASR, ROR by 1, ROR by 0.
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 32'h8000_0000, 5'd31, 2'b10, 1'b1);
        checkReady("asr", 1'b0, 1'b1);
        tick();
        checkOutput("asr", 1'b1, 32'hFFFF_FFFF, 1'b1);
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 32'h0000_0001, 5'd1, 2'b11, 1'b1);
        tick();
        checkOutput("ror1", 1'b1, 32'h8000_0000, 1'b1);
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b1, 32'h1234_5678, 5'd0, 2'b11, 1'b1);
        tick();
        checkOutput("ror0", 1'b1, 32'h1234_5678, 1'b1);
        applyStimulus(1'b1, 32'hF000_0000, 5'd4, 2'b01, 1'b0, '0, '0, 2'b00, 1'b1);
        tick();
        checkOutput("lsr", 1'b1, 32'h0F00_0000, 1'b0);

        // Hold 0xDEADBEEF under backpressure, then drain and refill together.
        applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd0, 2'b10, 1'b0, '0, '0, 2'b00, 1'b1);
        tick();
        checkOutput("load_hold", 1'b1, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h0000_000F, 5'd4, 2'b00, 1'b1, 32'h5, 5'd1, 2'b00, 1'b0);
            checkReady("hold", 1'b0, 1'b0);
            tick();
            checkOutput("hold", 1'b1, 32'hDEAD_BEEF, 1'b0);
        end
        applyStimulus(1'b1, 32'h0000_000F, 5'd4, 2'b00, 1'b0, '0, '0, 2'b00, 1'b1);
        checkReady("refill", 1'b1, 1'b0);
        tick();
        checkOutput("refill", 1'b1, 32'h0000_00F0, 1'b0);

        // Reset while full clears the slot without a clock edge.
        applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, '0, '0, 2'b00, 1'b0);
        tick();
        checkOutput("pre_reset", 1'b1, 32'h0000_00F0, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset", 1'b0, 32'd0, 1'b0);
        applyStimulus(1'b1, 32'h3, 5'd1, 2'b00, 1'b1, 32'h7, 5'd1, 2'b00, 1'b1);
        tick();
        reset_n = 1'b1;
        checkReady("post_reset", 1'b1, 1'b0);
        tick();
        checkOutput("post_reset", 1'b1, 32'h6, 1'b0);

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 6), $urandom(), randShamt(),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 9) < 6), $urandom(), randShamt(),
                          2'($urandom_range(0, 3)),
                          1'($urandom_range(0, 9) < 7));
            tick();
        end

        applyStimulus(1'b0, '0, '0, 2'b00, 1'b0, '0, '0, 2'b00, 1'b1);
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
